// File: rtl/bus_access_sequencer.sv
// bus_access_sequencer: runs one CPU bus transaction at a time through decode, chip select and wait states
// Ports: clk/nRESET (async active-low); req_valid/req_ready/req_we/req_addr/req_wdata request side;
// resp_valid/resp_rdata/resp_err response side; dec_addr/dec_sel/dec_hit registered decoder link;
// cs_n/oe_n/we_n/bus_wdata/bus_rdata device bus.
module bus_access_sequencer #(
  parameter int N        = 32,
  parameter int DW       = 16,
  parameter int WS_SRAM0 = 2,
  parameter int WS_SRAM1 = 2,
  parameter int WS_UART  = 4,
  parameter int WS_CTRL  = 1
) (
  input  logic          clk,
  input  logic          nRESET,
  input  logic          req_valid,
  input  logic          req_we,
  input  logic [N-1:0]  req_addr,
  input  logic [DW-1:0] req_wdata,
  output logic          req_ready,
  output logic          resp_valid,
  output logic [DW-1:0] resp_rdata,
  output logic          resp_err,
  output logic [N-1:0]  dec_addr,
  input  logic [1:0]    dec_sel,
  input  logic          dec_hit,
  output logic [3:0]    cs_n,
  output logic          oe_n,
  output logic          we_n,
  output logic [DW-1:0] bus_wdata,
  input  logic [DW-1:0] bus_rdata
);
  typedef enum logic [2:0] {IDLE, DECODE, SELECT, ACCESS, RESP} state_t;
  state_t        state_q;
  logic          we_q, ready_q, rvalid_q, err_q, oe_n_q, we_n_q;
  logic [DW-1:0] wdata_q, rdata_q, bus_wdata_q;
  logic [N-1:0]  addr_q;
  logic [3:0]    cs_n_q, cnt_q, ws_d;
  assign ws_d = dec_sel == 2'd0 ? 4'(WS_SRAM0) :
                dec_sel == 2'd1 ? 4'(WS_SRAM1) :
                dec_sel == 2'd2 ? 4'(WS_UART)  : 4'(WS_CTRL);
  assign req_ready  = ready_q;
  assign resp_valid = rvalid_q;
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;
  assign dec_addr   = addr_q;
  assign cs_n       = cs_n_q;
  assign oe_n       = oe_n_q;
  assign we_n       = we_n_q;
  assign bus_wdata  = bus_wdata_q;
  always_ff @(posedge clk or negedge nRESET)
    if (!nRESET) begin
      state_q     <= IDLE;
      we_q        <= 1'b0;
      wdata_q     <= '0;
      addr_q      <= '0;
      ready_q     <= 1'b0;
      rvalid_q    <= 1'b0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
      cs_n_q      <= 4'hF;
      oe_n_q      <= 1'b1;
      we_n_q      <= 1'b1;
      bus_wdata_q <= '0;
      cnt_q       <= '0;
    end else
      case (state_q)
        IDLE:
          if (req_valid && ready_q) begin
            we_q    <= req_we;
            wdata_q <= req_wdata;
            addr_q  <= req_addr;
            ready_q <= 1'b0;
            state_q <= DECODE;
          end else ready_q <= 1'b1;
        DECODE: state_q <= SELECT;
        SELECT:
          // dec_sel is only trusted on a hit, so an undefined select on a miss never reaches the strobes
          if (dec_hit) begin
            cnt_q       <= ws_d;
            cs_n_q      <= ~(4'b0001 << dec_sel);
            oe_n_q      <= we_q;
            we_n_q      <= ~we_q;
            bus_wdata_q <= we_q ? wdata_q : '0;
            state_q     <= ACCESS;
          end else begin
            err_q    <= 1'b1;
            rdata_q  <= '0;
            rvalid_q <= 1'b1;
            state_q  <= RESP;
          end
        ACCESS:
          if (cnt_q == 4'd0) begin
            rdata_q     <= we_q ? '0 : bus_rdata;
            err_q       <= 1'b0;
            rvalid_q    <= 1'b1;
            cs_n_q      <= 4'hF;
            oe_n_q      <= 1'b1;
            we_n_q      <= 1'b1;
            bus_wdata_q <= '0;
            state_q     <= RESP;
          end else cnt_q <= cnt_q - 4'd1;
        RESP: begin
          rvalid_q <= 1'b0;
          ready_q  <= 1'b1;
          state_q  <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
endmodule

// File: tb/tb_bus_access_sequencer.sv
// tb_bus_access_sequencer: directed vectors against a registered address-decoder model
module tb_bus_access_sequencer;
  logic        clk = 1'b0, nRESET = 1'b0, use_b = 1'b0;
  logic        req_valid = 1'b0, req_we = 1'b0;
  logic [31:0] req_addr = '0;
  logic [15:0] req_wdata = '0, bus_rdata = '0;
  logic        rdy_a, rv_a, err_a, oe_a, we_a, hit_a, rdy_b, rv_b, err_b, oe_b, we_b, hit_b;
  logic [15:0] rd_a, wd_a, rd_b, wd_b;
  logic [31:0] da_a, da_b;
  logic [3:0]  cs_a, cs_b;
  logic [1:0]  sel_a, sel_b;
  logic [2:0]  dreg_a, dreg_b;
  logic        req_ready, resp_valid, resp_err, oe_n, we_n;
  logic [15:0] resp_rdata, bus_wdata;
  logic [31:0] dec_addr;
  logic [3:0]  cs_n;
  int          n_vec = 0, n_err = 0;
  logic [3:0]  t_cs [1:31];
  logic        t_oe [1:31], t_we [1:31], t_rv [1:31], t_err [1:31], t_rdy [1:31];
  logic [15:0] t_wd [1:31], t_rd [1:31];
  logic [31:0] t_da [1:31];
  always #5 clk = ~clk;
  bus_access_sequencer u_dut_a (
    .clk(clk), .nRESET(nRESET), .req_valid(req_valid & ~use_b), .req_we(req_we), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_ready(rdy_a), .resp_valid(rv_a), .resp_rdata(rd_a), .resp_err(err_a),
    .dec_addr(da_a), .dec_sel(sel_a), .dec_hit(hit_a), .cs_n(cs_a), .oe_n(oe_a), .we_n(we_a),
    .bus_wdata(wd_a), .bus_rdata(bus_rdata));
  bus_access_sequencer #(.WS_SRAM0(0), .WS_SRAM1(0)) u_dut_b (
    .clk(clk), .nRESET(nRESET), .req_valid(req_valid & use_b), .req_we(req_we), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_ready(rdy_b), .resp_valid(rv_b), .resp_rdata(rd_b), .resp_err(err_b),
    .dec_addr(da_b), .dec_sel(sel_b), .dec_hit(hit_b), .cs_n(cs_b), .oe_n(oe_b), .we_n(we_b),
    .bus_wdata(wd_b), .bus_rdata(bus_rdata));
  assign req_ready  = use_b ? rdy_b : rdy_a;
  assign resp_valid = use_b ? rv_b : rv_a;
  assign resp_rdata = use_b ? rd_b : rd_a;
  assign resp_err   = use_b ? err_b : err_a;
  assign dec_addr   = use_b ? da_b : da_a;
  assign cs_n       = use_b ? cs_b : cs_a;
  assign oe_n       = use_b ? oe_b : oe_a;
  assign we_n       = use_b ? we_b : we_a;
  assign bus_wdata  = use_b ? wd_b : wd_a;
  function automatic logic [2:0] dmap(input logic [31:0] a);
    if (a[31:26] == 6'b000100) return 3'b100;
    if (a[31:26] == 6'b000101) return 3'b101;
    if (a >= 32'h4802_0000 && a <= 32'h4802_2FFF) return 3'b110;
    if (a >= 32'h44E1_0000 && a <= 32'h44E1_1FFF) return 3'b111;
    return 3'b000;
  endfunction
  always @(posedge clk) begin
    dreg_a <= dmap(da_a);
    dreg_b <= dmap(da_b);
  end
  assign hit_a = dreg_a[2];
  assign sel_a = dreg_a[2] ? dreg_a[1:0] : 2'bxx;
  assign hit_b = dreg_b[2];
  assign sel_b = dreg_b[2] ? dreg_b[1:0] : 2'bxx;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  always @(negedge clk) begin
    chk("inv_a", {31'd0, $countones(~cs_a) <= 1 && (oe_a | we_a)}, 32'd1);
    chk("inv_b", {31'd0, $countones(~cs_b) <= 1 && (oe_b | we_b)}, 32'd1);
  end
  task automatic run(input int n, input int drop_at, input logic [31:0] a2);
    for (int k = 1; k <= n; k++) begin
      @(negedge clk);
      t_cs[k] = cs_n; t_oe[k] = oe_n; t_we[k] = we_n; t_wd[k] = bus_wdata; t_rv[k] = resp_valid;
      t_rd[k] = resp_rdata; t_err[k] = resp_err; t_rdy[k] = req_ready; t_da[k] = dec_addr;
      if (k == 1) req_addr = a2;
      if (k == drop_at) req_valid = 1'b0;
    end
  endtask
  task automatic start(input logic we, input logic [31:0] a, input logic [15:0] wd);
    req_we = we; req_addr = a; req_wdata = wd; req_valid = 1'b1;
  endtask
  task automatic strb(input string tag, input logic [3:0] cs, input logic rd, input logic [15:0] wd,
                      input int n, input int first, input int len);
    int cnt = 0, f = 0, bad = 0;
    for (int k = 1; k <= n; k++)
      if (t_cs[k] == cs) begin
        cnt++;
        if (f == 0) f = k;
        if (rd ? !(t_oe[k] == 1'b0 && t_we[k] == 1'b1) : !(t_we[k] == 1'b0 && t_oe[k] == 1'b1 && t_wd[k] == wd)) bad++;
      end
    chk({tag, "_first"}, f, first);
    chk({tag, "_len"}, cnt, len);
    chk({tag, "_mode"}, bad, 0);
  endtask
  task automatic anychk(input string tag, input int n, input int exp);
    int cnt = 0;
    for (int k = 1; k <= n; k++) if (t_cs[k] != 4'hF || !t_oe[k] || !t_we[k]) cnt++;
    chk({tag, "_strobes"}, cnt, exp);
  endtask
  task automatic rvchk(input string tag, input int n, input int first, input int count);
    int cnt = 0, f = 0;
    for (int k = 1; k <= n; k++) if (t_rv[k]) begin cnt++; if (f == 0) f = k; end
    chk({tag, "_rv_cyc"}, f, first);
    chk({tag, "_rv_cnt"}, cnt, count);
  endtask
  initial begin
    int rv_seen;
    repeat (2) @(negedge clk);
    chk("rst_ready", rdy_a, 0);
    chk("rst_rv", rv_a, 0);
    chk("rst_err", err_a, 0);
    chk("rst_rdata", rd_a, 0);
    chk("rst_daddr", da_a, 0);
    chk("rst_cs", cs_a, 4'hF);
    chk("rst_strb", {oe_a, we_a}, 2'b11);
    chk("rst_wdata", wd_a, 0);
    nRESET = 1'b1;
    #1 chk("rel_ready0", rdy_a, 0);
    @(negedge clk);
    chk("rel_ready1", rdy_a, 1);
    bus_rdata = 16'hBEEF;
    start(1'b0, 32'h1000_0004, 16'h0);
    run(16, 1, 32'h1000_0004);
    chk("rd_daddr", t_da[1], 32'h1000_0004);
    strb("rd", 4'b1110, 1'b1, 16'h0, 16, 3, 3);
    anychk("rd", 16, 3);
    rvchk("rd", 16, 6, 1);
    chk("rd_rdata", t_rd[6], 16'hBEEF);
    chk("rd_err", t_err[6], 0);
    chk("rd_ready", {t_rdy[6], t_rdy[7]}, 2'b01);
    start(1'b1, 32'h4802_2010, 16'h0055);
    run(16, 1, 32'h4802_2010);
    strb("wr", 4'b1011, 1'b0, 16'h0055, 16, 3, 5);
    anychk("wr", 16, 5);
    rvchk("wr", 16, 8, 1);
    chk("wr_rdata", t_rd[8], 16'h0000);
    chk("wr_err", t_err[8], 0);
    start(1'b0, 32'h2000_0000, 16'h0);
    run(16, 1, 32'h2000_0000);
    anychk("miss", 16, 0);
    rvchk("miss", 16, 3, 1);
    chk("miss_err", t_err[3], 1);
    chk("miss_rdata", t_rd[3], 0);
    chk("miss_ready", {t_rdy[3], t_rdy[4]}, 2'b01);
    chk("miss_hold", t_err[12], 1);
    start(1'b0, 32'h1400_0000, 16'h0);
    run(24, 8, 32'h44E1_0000);
    rvchk("b2b", 24, 6, 2);
    chk("b2b_ready", {t_rdy[6], t_rdy[7], t_rdy[8]}, 3'b010);
    chk("b2b_daddr2", t_da[8], 32'h44E1_0000);
    strb("b2b_s1", 4'b1101, 1'b1, 16'h0, 24, 3, 3);
    strb("b2b_ctl", 4'b0111, 1'b1, 16'h0, 24, 10, 2);
    anychk("b2b", 24, 5);
    chk("b2b_rv2", {t_rv[12], t_err[12]}, 2'b10);
    chk("b2b_rdata2", t_rd[12], 16'hBEEF);
    start(1'b1, 32'h1400_0000, 16'hA5A5);
    run(3, 1, 32'h1400_0000);
    chk("ar_pre", {t_cs[3], t_we[3]}, {4'b1101, 1'b0});
    #2 nRESET = 1'b0;
    #1 chk("ar_cs", cs_a, 4'hF);
    chk("ar_we", we_a, 1);
    chk("ar_ready", rdy_a, 0);
    chk("ar_wdata", wd_a, 0);
    run(3, 0, 32'h1400_0000);
    rv_seen = int'(t_rv[1]) + int'(t_rv[2]) + int'(t_rv[3]) + int'(t_rdy[3]);
    nRESET = 1'b1;
    #1 chk("ar_rel0", rdy_a, 0);
    run(8, 0, 32'h1400_0000);
    for (int k = 1; k <= 8; k++) rv_seen += int'(t_rv[k]);
    chk("ar_rv_none", rv_seen, 0);
    chk("ar_rel1", t_rdy[1], 1);
    use_b = 1'b1;
    start(1'b0, 32'h13FF_FFFF, 16'h0);
    run(10, 1, 32'h13FF_FFFF);
    strb("bd_lo", 4'b1110, 1'b1, 16'h0, 10, 3, 1);
    anychk("bd_lo", 10, 1);
    rvchk("bd_lo", 10, 4, 1);
    start(1'b0, 32'h1400_0000, 16'h0);
    run(10, 1, 32'h1400_0000);
    strb("bd_hi", 4'b1101, 1'b1, 16'h0, 10, 3, 1);
    anychk("bd_hi", 10, 1);
    rvchk("bd_hi", 10, 4, 1);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
